// File: rtl/rc4_pkg.sv
// ----------------------------------------------------------------------------
// rc4_pkg
// Shared types and constants for the RC4 loopback cipher block.
//   rc4_byte_t  : one cipher/plain byte
//   rc4_state_e : core sequencer state (INIT_S -> KSA -> READY)
//   SBOX_SIZE   : number of S-box entries
// ----------------------------------------------------------------------------
package rc4_pkg;

   typedef logic [7:0] rc4_byte_t;

   typedef enum logic [1:0] {
      INIT_S = 2'd0,
      KSA    = 2'd1,
      READY  = 2'd2
   } rc4_state_e;

   localparam int SBOX_SIZE = 256;

endpackage

// File: rtl/rc4_core.sv
// ----------------------------------------------------------------------------
// rc4_core
// One RC4 engine: 256x8 register S-box, identity-fill / key-schedule sequencer
// and a single-step PRGA.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   i_key    in   1-byte key, latched on the first edge after reset release
//   i_step   in   advance the PRGA by one byte (honoured only in READY)
//   o_k      out  keystream byte the next step produces (combinational)
//   o_ready  out  sequencer has finished key scheduling
// ----------------------------------------------------------------------------
module rc4_core
   import rc4_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  rc4_byte_t i_key,
   input  logic      i_step,
   output rc4_byte_t o_k,
   output logic      o_ready
);

   rc4_byte_t  r_s [SBOX_SIZE];
   rc4_state_e r_state;
   rc4_byte_t  r_i;
   rc4_byte_t  r_j;
   rc4_byte_t  r_key;

   rc4_byte_t  w_pi, w_pj, w_si, w_sj, w_idx;
   rc4_byte_t  w_kj, w_ksi, w_ksj;

   assign o_ready = (r_state == READY);

   // PRGA lookahead; K is read from the post-swap S-box by forwarding the
   // two swapped entries instead of waiting for the write-back.
   always_comb begin
      w_pi  = r_i + 8'd1;
      w_si  = r_s[w_pi];
      w_pj  = r_j + w_si;
      w_sj  = r_s[w_pj];
      w_idx = w_si + w_sj;
      if (w_idx == w_pi) begin
         o_k = w_sj;
      end else if (w_idx == w_pj) begin
         o_k = w_si;
      end else begin
         o_k = r_s[w_idx];
      end
   end

   // Key-schedule swap partners for the current KSA index
   always_comb begin
      w_ksi = r_s[r_i];
      w_kj  = r_j + w_ksi + r_key;
      w_ksj = r_s[w_kj];
   end

   // Sequencer: identity fill, key schedule, then PRGA steps on request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= INIT_S;
         r_i     <= 8'd0;
         r_j     <= 8'd0;
         r_key   <= 8'd0;
         for (int k = 0; k < SBOX_SIZE; k++) begin
            r_s[k] <= 8'd0;
         end
      end else begin
         case (r_state)
            INIT_S: begin
               // r_i is zero only on the first edge after reset release
               if (r_i == 8'd0) begin
                  r_key <= i_key;
               end
               r_s[r_i] <= r_i;
               r_i      <= r_i + 8'd1;
               if (r_i == 8'd255) begin
                  r_state <= KSA;
                  r_j     <= 8'd0;
               end
            end
            KSA: begin
               r_s[r_i] <= w_ksj;
               r_s[w_kj] <= w_ksi;
               r_i      <= r_i + 8'd1;
               if (r_i == 8'd255) begin
                  r_state <= READY;
                  r_j     <= 8'd0;
               end else begin
                  r_j     <= w_kj;
               end
            end
            READY: begin
               if (i_step) begin
                  r_s[w_pi] <= w_sj;
                  r_s[w_pj] <= w_si;
                  r_i       <= w_pi;
                  r_j       <= w_pj;
               end
            end
            default: begin
               r_state <= INIT_S;
               r_i     <= 8'd0;
               r_j     <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: rtl/rc4_enc_dec_top.sv
// ----------------------------------------------------------------------------
// rc4_enc_dec_top
// RC4 loopback: plaintext is encrypted into a ciphertext FIFO, and the FIFO
// is drained through an identically keyed decryptor to data_out.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   password  in   1-byte RC4 key, latched on the first edge after reset
//   data_in   in   plaintext byte
//   valid1    in   encrypt data_in and push it into the FIFO
//   valid     in   pop, decrypt and register the result on data_out
//   data_out  out  registered output byte
// Parameter FIFO_DEPTH: ciphertext entries, power of two.
// Build option RC4_CIPHER_OUT_EN: data_out also shows the ciphertext being
// pushed on cycles that push without popping.
// ----------------------------------------------------------------------------
module rc4_enc_dec_top
   import rc4_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
)(
   input  logic      clk,
   input  logic      rst,
   input  rc4_byte_t password,
   input  rc4_byte_t data_in,
   input  logic      valid1,
   input  logic      valid,
   output rc4_byte_t data_out
);

   localparam int AW = $clog2(FIFO_DEPTH);

   rc4_byte_t   r_fifo [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;

   rc4_byte_t   w_k_enc, w_k_dec;
   logic        w_ready_enc, w_ready_dec, w_ready;
   logic        w_full, w_empty, w_push, w_pop;

   rc4_core u_enc (
      .clk     (clk),
      .rst     (rst),
      .i_key   (password),
      .i_step  (w_push),
      .o_k     (w_k_enc),
      .o_ready (w_ready_enc)
   );

   rc4_core u_dec (
      .clk     (clk),
      .rst     (rst),
      .i_key   (password),
      .i_step  (w_pop),
      .o_k     (w_k_dec),
      .o_ready (w_ready_dec)
   );

   assign w_ready = w_ready_enc & w_ready_dec;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = w_ready & valid & ~w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign w_push  = w_ready & valid1 & (~w_full | w_pop);

   // Ciphertext FIFO storage and pointers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            r_fifo[k] <= 8'd0;
         end
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= data_in ^ w_k_enc;
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Output register: decrypted head on pop, otherwise hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out <= 8'd0;
      end else if (w_pop) begin
         data_out <= r_fifo[r_rd_ptr[AW-1:0]] ^ w_k_dec;
`ifdef RC4_CIPHER_OUT_EN
      end else if (w_push) begin
         data_out <= data_in ^ w_k_enc;
`endif
      end else begin
         data_out <= data_out;
      end
   end

endmodule

// File: tb/tb_rc4_enc_dec_top.sv
// ----------------------------------------------------------------------------
// tb_rc4_enc_dec_top
// Self-checking bench for rc4_enc_dec_top (default build, cipher-out off).
// ----------------------------------------------------------------------------
module tb_rc4_enc_dec_top;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] password;
   logic [7:0] data_in;
   logic       valid1;
   logic       valid;
   logic [7:0] data_out;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] sb_q[$];
   logic [7:0] last_out;
   logic       ready_m;

   logic [7:0] ms [256];
   logic [7:0] mi, mj;

   typedef struct {
      logic       v1;
      logic       v;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [21];

   always #5 clk = ~clk;

   rc4_enc_dec_top #(.FIFO_DEPTH(16)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .password (password),
      .data_in  (data_in),
      .valid1   (valid1),
      .valid    (valid),
      .data_out (data_out)
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference RC4 with a 1-byte key
   task automatic model_init(input logic [7:0] key);
      logic [7:0] j, t;
      for (int k = 0; k < 256; k++) ms[k] = 8'(k);
      j = 8'd0;
      for (int k = 0; k < 256; k++) begin
         j = j + ms[k] + key;
         t = ms[k]; ms[k] = ms[j]; ms[j] = t;
      end
      mi = 8'd0;
      mj = 8'd0;
   endtask

   function automatic logic [7:0] model_next();
      logic [7:0] t;
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
      t = ms[mi] + ms[mj];
      return ms[t];
   endfunction

   // One cycle of stimulus with scoreboard bookkeeping and output check
   task automatic cyc(input logic v1, input logic v, input logic [7:0] din);
      logic pop, push;
      valid1  = v1;
      valid   = v;
      data_in = din;
      pop  = ready_m && v && (sb_q.size() > 0);
      push = ready_m && v1 && ((sb_q.size() < 16) || pop);
      if (pop) last_out = sb_q.pop_front();
      if (push) sb_q.push_back(din);
      tick();
      valid1 = 1'b0;
      valid  = 1'b0;
      chk("data_out", data_out, last_out);
   endtask

   task automatic do_reset(input logic [7:0] key);
      valid1   = 1'b0;
      valid    = 1'b0;
      data_in  = 8'd0;
      password = key;
      rst      = 1'b0;
      ready_m  = 1'b0;
      sb_q.delete();
      last_out = 8'd0;
      repeat (3) tick();
      chk("rst_data_out", data_out, 8'd0);
      chk("rst_ready", {7'd0, u_dut.w_ready}, 8'd0);
      chk("rst_empty", {7'd0, u_dut.w_empty}, 8'd1);
      rst = 1'b1;
   endtask

   initial begin
      logic [7:0] ks;
      tbl[0]  = '{1'b1, 1'b0, 8'd5,  8'd0};
      tbl[1]  = '{1'b1, 1'b0, 8'd10, 8'd0};
      tbl[2]  = '{1'b1, 1'b0, 8'd20, 8'd0};
      tbl[3]  = '{1'b1, 1'b0, 8'd30, 8'd0};
      tbl[4]  = '{1'b1, 1'b0, 8'd40, 8'd0};
      tbl[5]  = '{1'b1, 1'b0, 8'd40, 8'd0};
      tbl[6]  = '{1'b1, 1'b0, 8'd40, 8'd0};
      tbl[7]  = '{1'b1, 1'b0, 8'd40, 8'd0};
      tbl[8]  = '{1'b0, 1'b1, 8'd0,  8'd5};
      tbl[9]  = '{1'b0, 1'b1, 8'd0,  8'd10};
      tbl[10] = '{1'b0, 1'b1, 8'd0,  8'd20};
      tbl[11] = '{1'b0, 1'b1, 8'd0,  8'd30};
      for (int k = 12; k < 21; k++) tbl[k] = '{1'b0, 1'b1, 8'd0, 8'd40};

      // Test 1: basic loopback from the table
      do_reset(8'hA0);
      repeat (850) tick();
      ready_m = 1'b1;
      chk("ready_after_init", {7'd0, u_dut.w_ready}, 8'd1);
      for (int k = 0; k < 21; k++) begin
         cyc(tbl[k].v1, tbl[k].v, tbl[k].din);
         if (tbl[k].v) chk("table_out", data_out, tbl[k].exp);
      end
      // Stored ciphertext against the reference keystream
      model_init(8'hA0);
      for (int k = 0; k < 8; k++) begin
         ks = model_next();
         chk("cipher", u_dut.r_fifo[k], tbl[k].din ^ ks);
      end

      // Test 2: second burst on the same key, bytes doubled
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b0, tbl[k].din);
         cyc(1'b1, 1'b0, tbl[k].din);
      end
      repeat (11) cyc(1'b0, 1'b1, 8'd0);

      // Test 3: overfill, then push+pop while full, then drain
      for (int k = 1; k <= 20; k++) cyc(1'b1, 1'b0, 8'(k));
      chk("full_flag", {7'd0, u_dut.w_full}, 8'd1);
      cyc(1'b1, 1'b1, 8'h99);
      repeat (17) cyc(1'b0, 1'b1, 8'd0);
      chk("empty_after_drain", {7'd0, u_dut.w_empty}, 8'd1);

      // Test 4: streaming with simultaneous push/pop
      for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 8'(k));
      for (int k = 8; k < 32; k++) cyc(1'b1, 1'b1, 8'(k));
      repeat (9) cyc(1'b0, 1'b1, 8'd0);

      // Test 5: push during init is ignored
      do_reset(8'h3C);
      repeat (99) tick();
      cyc(1'b1, 1'b0, 8'h77);
      chk("init_empty", {7'd0, u_dut.w_empty}, 8'd1);
      repeat (750) tick();
      ready_m = 1'b1;
      cyc(1'b1, 1'b0, 8'h11);
      cyc(1'b1, 1'b0, 8'h22);
      cyc(1'b1, 1'b0, 8'h33);
      repeat (4) cyc(1'b0, 1'b1, 8'd0);

      // Test 6: reset in the middle of a drain
      for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 8'(8'h40 + k));
      cyc(1'b0, 1'b1, 8'd0);
      cyc(1'b0, 1'b1, 8'd0);
      valid = 1'b1;
      rst   = 1'b0;
      #1;
      chk("async_rst_out", data_out, 8'd0);
      chk("async_rst_ready", {7'd0, u_dut.w_ready}, 8'd0);
      chk("async_rst_empty", {7'd0, u_dut.w_empty}, 8'd1);
      valid    = 1'b0;
      ready_m  = 1'b0;
      sb_q.delete();
      last_out = 8'd0;
      password = 8'hA0;
      tick();
      rst = 1'b1;
      repeat (500) tick();
      chk("reinit_not_ready", {7'd0, u_dut.w_ready}, 8'd0);
      repeat (30) tick();
      chk("reinit_ready", {7'd0, u_dut.w_ready}, 8'd1);
      ready_m = 1'b1;
      cyc(1'b1, 1'b0, 8'd5);
      cyc(1'b0, 1'b1, 8'd0);
      chk("reinit_loopback", data_out, 8'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rc4_enc_dec_top.md
# rc4_enc_dec_top

The RC4 loopback cipher block. It expands an 8-bit password into two identical RC4 states: an encryptor and a decryptor. Plaintext bytes on `data_in` are encrypted into an internal ciphertext FIFO, and the FIFO is later drained through the decryptor to `data_out`. It sits between the byte-stream source and sink as a self-checking encrypt/decrypt datapath.

## Interface
- `FIFO_DEPTH`, 16: ciphertext buffer entries (power of two).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `password`  in  8  RC4 key (1-byte key); sampled once at start of init.
- `data_in`  in  8  plaintext byte.
- `valid1`  in  1  `data_in` valid this cycle; encrypt and push.
- `valid`  in  1  drain request; pop, decrypt, present on `data_out`.
- `data_out`  out  8  registered output byte.

## Operation
- States: `INIT_S` → `KSA` → `READY`.
  - `INIT_S`: `S[i]=i` for both cores, 256 cycles.
  - `KSA`: one swap per cycle, i=0..255, `j=j+S[i]+password` mod 256.
  - `READY`: permanent until reset.
- `password` is latched on the first rising edge after `rst` deasserts. Later changes are ignored until the next reset.
- PRGA step, per byte, all mod 256:
  - `i=i+1`
  - `j=j+S[i]`
  - swap `S[i]`, `S[j]`
  - `K=S[S[i]+S[j]]`, using post-swap values (forward combinationally within the cycle).
- Encrypt: in `READY` with `valid1=1` and FIFO not full, push `data_in ^ K_enc` and advance the encryptor PRGA.
  - `valid1` before `READY` is dropped; no PRGA advance.
  - `valid1` with FIFO full is dropped; no PRGA advance.
- Decrypt: in `READY` with `valid=1` and FIFO not empty, pop head, `data_out <= head ^ K_dec`, and advance the decryptor PRGA.
  - `valid` with FIFO empty: `data_out` holds, no advance.
- Simultaneous push and pop are allowed, including at full (pop frees the slot in the same cycle) and at empty (no pop; push only).
- Both cores receive the same key and the same byte count, so the decrypted stream equals the accepted plaintext stream in order.

## Timing
- Reset (`rst=0`) state:
  - `data_out=0`
  - FIFO empty
  - state `INIT_S`
  - i, j, counters 0
- `READY` is reached 512 cycles after the password-latch edge (+1 registration cycle). Sources wait at least 520 cycles.
- Encrypt latency: byte pushed on the edge where `valid1` is sampled; 1-byte/cycle throughput.
- Decrypt latency: `data_out` updates on the edge sampling `valid`; visible 1 cycle after assertion; 1 byte/cycle.
- Reset mid-operation immediately clears everything and restarts init; FIFO contents are lost.
- Pointer wrap: read/write pointers carry an extra MSB for full/empty discrimination.

## Configuration
- `RC4_CIPHER_OUT_EN` defined: during cycles with an accepted `valid1` and no pop, `data_out` also registers the ciphertext byte being pushed. A pop takes priority.
- Undefined: `data_out` changes only on pops.

## Structure
- Shared package `rc4_pkg`: byte type, state enum (`INIT_S`, `KSA`, `READY`), constant `SBOX_SIZE=256`.
- One sub-module `rc4_core`, instantiated twice (encryptor, decryptor). It contains:
  - a 256×8 register-array S-box
  - the init/KSA sequencer
  - the PRGA with a `step` input and a combinational `K` output.
- The FIFO is inline in the top.

## Test plan
- Reset then `password=0xA0`, wait 850 cycles; `valid1` for 8 cycles with `data_in` 5,10,20,30,40,40,40,40; then `valid` 13 cycles → `data_out` sequence 5,10,20,30,40,40,40,40, then holds 40.
- Second burst on the same key: 5,10,20,30,40 (each held 2 cycles, i.e. 10 pushes), then drain → exactly those 10 bytes in order; keystream continues, no reinit.
- `valid1` during init (cycle 100) → ignored; a later drain returns only post-`READY` bytes.
- Push 20 bytes without draining → first 16 stored, last 4 dropped; drain yields bytes 1..16.
- Simultaneous `valid1`/`valid` streaming 0..31 from 8 pre-filled entries → output order preserved, no loss.
- Assert `rst` low mid-drain → `data_out=0`, FIFO empty, `READY` deasserted for 512 cycles; after re-init, the loopback of 5 returns 5.
